dm_responder: RTL

Data-memory responder for the pipelined MIPS core. It is the memory-side end of the load/store interface that the M stage initiates. It accepts one request at a time over a valid/ready handshake, waits a configurable number of cycles, then commits the write or captures the read word. It returns the result over a second valid/ready channel and logs committed stores in the course's `@pc: *addr <= data` format. It replaces the zero-latency DM so that the pipeline's stall logic can be exercised against a slow memory.

---
 rtl/dm_responder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dm_responder.sv
// Data-memory responder: single outstanding request, fixed commit latency,
// registered response channel with backpressure and an optional store log.
module dm_responder #(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter bit          LOG_WRITES  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] pc_q;
   logic        req_ready_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;
   logic        busy_q;
   logic [31:0] mem_q [DEPTH];

   logic          accept;
   logic          commit;
   logic          c_we;
   logic [3:0]    c_be;
   logic [31:0]   c_addr;
   logic [31:0]   c_wdata;
   logic [31:0]   c_pc;
   logic          c_err;
   logic [AW-1:0] c_idx;
   logic [31:0]   old_word;
   logic [31:0]   merged_d;

   assign accept = (state_q == S_IDLE) && req_valid;
   assign commit = (accept && (WAIT_CYCLES == 0)) ||
                   ((state_q == S_WAIT) && (cnt_q == 4'd1));

   // With zero wait the commit happens on the accepting edge, so the operands
   // come straight from the request bus instead of the latched copies.
   assign c_we    = (state_q == S_IDLE) ? req_we    : we_q;
   assign c_be    = (state_q == S_IDLE) ? req_be    : be_q;
   assign c_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
   assign c_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
   assign c_pc    = (state_q == S_IDLE) ? req_pc    : pc_q;

   assign c_err    = (c_addr[1:0] != 2'b00) || ({2'b00, c_addr[31:2]} >= DEPTH);
   assign c_idx    = c_addr[AW+1:2];
   assign old_word = mem_q[c_idx];

   always_comb begin
      merged_d = old_word;
      for (int unsigned i = 0; i < 4; i++) begin
         if (c_be[i]) merged_d[8*i +: 8] = c_wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_INIT;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         be_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         pc_q        <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         case (state_q)
            S_INIT: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b1;
            end
            S_IDLE: begin
               if (req_valid) begin
                  we_q        <= req_we;
                  be_q        <= req_be;
                  addr_q      <= req_addr;
                  wdata_q     <= req_wdata;
                  pc_q        <= req_pc;
                  cnt_q       <= 4'(WAIT_CYCLES);
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state_q     <= S_RESP;
                     rsp_valid_q <= 1'b1;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state_q     <= S_IDLE;
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: state_q <= S_INIT;
         endcase

         if (commit) begin
            if (!c_err && c_we) mem_q[c_idx] <= merged_d;
            rsp_rdata_q <= (!c_err && !c_we) ? old_word : '0;
            rsp_err_q   <= c_err;
         end
      end
   end

   if (LOG_WRITES) begin : g_log
      always_ff @(posedge clk) begin
         if (reset && commit && c_we && !c_err && (c_be != 4'h0))
            $display("@%h: *%h <= %h", c_pc, {c_addr[31:2], 2'b00}, merged_d);
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = busy_q;

endmodule
